pwm_axi_multi: RTL and testbench

- Multi-channel AXI4-Lite PWM peripheral; successor to the single-channel 4-register PWM_AXI slave.
- Adds the following over the single-channel block:
  - parametrised channel count and counter width;
  - a shared period counter;
  - double-buffered period/duty registers, committed at period wrap (glitch-free updates);
  - complementary high/low outputs with programmable dead time.
- Sits behind the PS interconnect and drives gate-driver pins of the inductive power stage.

---
 rtl/pwm_axi_multi.sv | 207 ++++++++++++++++++++
 tb/tb_pwm_axi_multi.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_axi_multi.sv
// Multi-channel PWM behind an AXI4-Lite slave. All channels share one period counter.
// Each channel has a double-buffered duty value and drives complementary outputs separated by a dead time.
module pwm_axi_multi #(
    parameter int NUM_CH             = 4,
    parameter int CNT_W              = 16,
    parameter int DT_W               = 8,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [NUM_CH-1:0]               pwm_h,
    output logic [NUM_CH-1:0]               pwm_l,
    output logic                            period_irq
);

    logic                         awready_reg, wready_reg, bvalid_reg;
    logic                         arready_reg, rvalid_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg;

    logic [NUM_CH-1:0]            en_reg;
    logic                         run_reg;
    logic [CNT_W-1:0]             period_sh_reg, period_act_reg, cnt_reg;
    logic [DT_W-1:0]              dt_reg;
    logic                         pending_reg;

    logic [NUM_CH-1:0][CNT_W-1:0] duty_sh_bus;
    logic [15:0][31:0]            word_view;
    logic [31:0]                  cnt_wide, wr_merged;
    logic [3:0]                   wr_idx, rd_idx;
    logic                         wr_fire, rd_fire, wr_ctrl, wr_period, wr_dt;
    logic [NUM_CH-1:0]            wr_duty;
    logic                         wrap, commit;
    logic                         unused_ok;

    assign s00_axi_awready = awready_reg;
    assign s00_axi_wready  = wready_reg;
    assign s00_axi_bvalid  = bvalid_reg;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = arready_reg;
    assign s00_axi_rvalid  = rvalid_reg;
    assign s00_axi_rdata   = rdata_reg;
    assign s00_axi_rresp   = 2'b00;

    assign wr_idx   = s00_axi_awaddr[5:2];
    assign rd_idx   = s00_axi_araddr[5:2];
    assign wr_fire  = awready_reg && s00_axi_awvalid && wready_reg && s00_axi_wvalid;
    assign rd_fire  = arready_reg && s00_axi_arvalid;
    assign cnt_wide = 32'(cnt_reg);

    // Word-indexed view of the programmed (shadow) register file, shared by reads and strobed writes.
    always_comb begin
        word_view    = '0;
        word_view[0] = {run_reg, {(31-NUM_CH){1'b0}}, en_reg};
        word_view[1] = 32'(period_sh_reg);
        word_view[2] = 32'(dt_reg);
        word_view[3] = {cnt_wide[15:0], 15'd0, pending_reg};
        for (int i = 0; i < NUM_CH; i++) begin
            word_view[4+i] = 32'(duty_sh_bus[i]);
        end
    end

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            wr_merged[8*b +: 8] = s00_axi_wstrb[b] ? s00_axi_wdata[8*b +: 8] : word_view[wr_idx][8*b +: 8];
        end
    end

    always_comb begin
        wr_ctrl   = wr_fire && (wr_idx == 4'd0);
        wr_period = wr_fire && (wr_idx == 4'd1);
        wr_dt     = wr_fire && (wr_idx == 4'd2);
        for (int i = 0; i < NUM_CH; i++) begin
            wr_duty[i] = wr_fire && (wr_idx == 4'(i + 4));
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            if (!awready_reg && s00_axi_awvalid && s00_axi_wvalid && !bvalid_reg) begin
                awready_reg <= 1'b1;
                wready_reg  <= 1'b1;
            end else begin
                awready_reg <= 1'b0;
                wready_reg  <= 1'b0;
            end
            if (wr_fire) begin
                bvalid_reg <= 1'b1;
            end else if (s00_axi_bready) begin
                bvalid_reg <= 1'b0;
            end
            arready_reg <= !arready_reg && s00_axi_arvalid && !rvalid_reg;
            if (rd_fire) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= word_view[rd_idx];
            end else if (s00_axi_rready) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    assign wrap       = run_reg && (cnt_reg == period_act_reg);
    assign commit     = !run_reg || wrap;
    assign period_irq = wrap;

    // A write landing on a wrap cycle goes to the shadow and must leave pending set.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            en_reg         <= '0;
            run_reg        <= 1'b0;
            period_sh_reg  <= '0;
            period_act_reg <= '0;
            dt_reg         <= '0;
            cnt_reg        <= '0;
            pending_reg    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en_reg  <= wr_merged[NUM_CH-1:0];
                run_reg <= wr_merged[31];
            end
            if (wr_period) period_sh_reg <= CNT_W'(wr_merged);
            if (wr_dt)     dt_reg        <= DT_W'(wr_merged);
            if (commit)    period_act_reg <= period_sh_reg;
            if (!run_reg) begin
                cnt_reg     <= '0;
                pending_reg <= 1'b0;
            end else begin
                cnt_reg <= wrap ? '0 : cnt_reg + CNT_W'(1);
                if (wrap) pending_reg <= 1'b0;
                if (wr_period || (|wr_duty)) pending_reg <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] duty_sh_reg, duty_act_reg;
        logic [DT_W-1:0]  stable_reg, stable_next;
        logic             act, raw, raw_prev_reg, act_prev_reg, dt_ok;
        logic             h_reg, l_reg;

        assign act = en_reg[gi] && run_reg;
        assign raw = act && (cnt_reg < duty_act_reg);

        // Cycles raw has held its level; restarts on every raw edge and whenever the channel (re)activates.
        always_comb begin
            stable_next = '0;
            if (act && act_prev_reg && (raw == raw_prev_reg)) begin
                stable_next = (&stable_reg) ? stable_reg : stable_reg + DT_W'(1);
            end
        end
        assign dt_ok = (stable_next >= dt_reg);

        always_ff @(posedge s00_axi_aclk) begin
            if (!s00_axi_aresetn) begin
                duty_sh_reg  <= '0;
                duty_act_reg <= '0;
                stable_reg   <= '0;
                raw_prev_reg <= 1'b0;
                act_prev_reg <= 1'b0;
                h_reg        <= 1'b0;
                l_reg        <= 1'b0;
            end else begin
                if (wr_duty[gi]) duty_sh_reg  <= CNT_W'(wr_merged);
                if (commit)      duty_act_reg <= duty_sh_reg;
                stable_reg   <= stable_next;
                raw_prev_reg <= raw;
                act_prev_reg <= act;
                h_reg        <= raw && dt_ok;
                l_reg        <= act && !raw && dt_ok;
            end
        end

        assign duty_sh_bus[gi] = duty_sh_reg;
        assign pwm_h[gi]       = h_reg;
        assign pwm_l[gi]       = l_reg;
    end

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                         s00_axi_araddr[1:0], wr_merged, cnt_wide};

endmodule

// File: tb/tb_pwm_axi_multi.sv
// Directed bench for pwm_axi_multi: register access, PWM waveforms, dead time, buffering and reset.
module tb_pwm_axi_multi;
    localparam int NUM_CH = 4;

    logic              tb_ACLK = 1'b0;
    logic              aresetn;
    logic [5:0]        awaddr, araddr;
    logic [2:0]        awprot, arprot;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [31:0]       wdata, rdata;
    logic [3:0]        wstrb;
    logic [1:0]        bresp, rresp;
    logic [NUM_CH-1:0] pwm_h, pwm_l;
    logic              period_irq;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] h_pat [NUM_CH];
    logic [9:0] l_pat [NUM_CH];
    int         win_irqs, win_overlap;

    always #5 tb_ACLK = ~tb_ACLK;

    pwm_axi_multi #(.NUM_CH(NUM_CH), .CNT_W(16), .DT_W(8)) dut (
        .s00_axi_aclk(tb_ACLK), .s00_axi_aresetn(aresetn),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready), .pwm_h(pwm_h), .pwm_l(pwm_l), .period_irq(period_irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input bit do_b, output logic [1:0] resp);
        int n = 0;
        tick();
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        while (!(awready && wready) && n < 20) begin tick(); n++; end
        if (n >= 20) check("wr_handshake_timeout", 32'(awready), 32'd1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        resp = 2'b00;
        if (do_b) begin
            n = 0;
            while (!bvalid && n < 20) begin tick(); n++; end
            if (n >= 20) check("bvalid_timeout", 32'(bvalid), 32'd1);
            resp = bresp;
            bready = 1'b1;
            tick();
            bready = 1'b0;
        end
        $display("WR  addr=0x%02h data=0x%08h strb=%b bresp=%0d", addr, data, strb, resp);
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        tick();
        araddr = addr; arvalid = 1'b1;
        while (!arready && n < 20) begin tick(); n++; end
        if (n >= 20) check("rd_handshake_timeout", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        if (n >= 20) check("rvalid_timeout", 32'(rvalid), 32'd1);
        data = rdata; resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
        $display("RD  addr=0x%02h data=0x%08h rresp=%0d", addr, data, resp);
    endtask

    // Syncs to a wrap cycle (k=0) and records outputs for k=1..10, i.e. one 10-cycle period.
    task automatic capture_period();
        int n = 0;
        while (!period_irq && n < 60) begin tick(); n++; end
        check("irq_sync", 32'(period_irq), 32'd1);
        win_irqs = 0; win_overlap = 0;
        for (int c = 0; c < NUM_CH; c++) begin h_pat[c] = '0; l_pat[c] = '0; end
        for (int k = 1; k <= 10; k++) begin
            tick();
            for (int c = 0; c < NUM_CH; c++) begin
                h_pat[c][k-1] = pwm_h[c];
                l_pat[c][k-1] = pwm_l[c];
            end
            win_irqs += int'(period_irq);
            if ((pwm_h & pwm_l) != '0) win_overlap++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          hcnt, n;

        aresetn = 1'b0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0;
        repeat (3) tick();

        // Reset state and register file after reset.
        check("rst_handshakes", 32'({awready, wready, arready, bvalid, rvalid}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_outputs", 32'({pwm_h, pwm_l, period_irq}), 32'd0);
        aresetn = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) begin
            axi_read(6'(a * 4), d, r);
            check($sformatf("rst_rd_%02h", a * 4), d, 32'd0);
            check($sformatf("rst_rresp_%02h", a * 4), 32'(r), 32'd0);
        end
        axi_write(6'h34, 32'hDEADBEEF, 4'hF, 1'b1, r);
        check("unmapped_bresp", 32'(r), 32'd0);
        axi_read(6'h34, d, r);
        check("unmapped_rd", d, 32'd0);

        // Basic PWM, dead time 0.
        axi_write(6'h04, 32'd9, 4'hF, 1'b1, r);
        axi_write(6'h10, 32'd3, 4'hF, 1'b1, r);
        axi_write(6'h08, 32'd0, 4'hF, 1'b1, r);
        axi_write(6'h00, 32'h80000001, 4'hF, 1'b1, r);
        axi_read(6'h00, d, r);
        check("ctrl_rd", d, 32'h80000001);
        axi_read(6'h04, d, r);
        check("period_rd", d, 32'd9);
        capture_period();
        check("d0_h0_pat", 32'(h_pat[0]), 32'h00E);
        check("d0_l0_pat", 32'(l_pat[0]), 32'h3F1);
        check("d0_irqs", 32'(win_irqs), 32'd1);
        check("d0_overlap", 32'(win_overlap), 32'd0);
        capture_period();
        check("d0_irqs_2nd", 32'(win_irqs), 32'd1);
        check("d0_h0_pat_2nd", 32'(h_pat[0]), 32'h00E);
        axi_read(6'h0C, d, r);
        check("status_idle_pend", d & 32'd1, 32'd0);

        // Dead time 2.
        axi_write(6'h08, 32'd2, 4'hF, 1'b1, r);
        capture_period();
        check("dt2_h0_pat", 32'(h_pat[0]), 32'h008);
        check("dt2_l0_pat", 32'(l_pat[0]), 32'h3C1);
        check("dt2_overlap", 32'(win_overlap), 32'd0);

        // Duty change mid-period only takes effect after the wrap.
        axi_write(6'h10, 32'd7, 4'hF, 1'b1, r);
        axi_read(6'h0C, d, r);
        check("status_pending", d & 32'd1, 32'd1);
        hcnt = 0; n = 0;
        while (!period_irq && n < 60) begin hcnt += int'(pwm_h[0]); tick(); n++; end
        hcnt += int'(pwm_h[0]);
        check("no_runt_before_wrap", 32'(hcnt), 32'd0);
        capture_period();
        check("dt2_new_h0_pat", 32'(h_pat[0]), 32'h0F8);
        check("dt2_new_l0_pat", 32'(l_pat[0]), 32'h001);
        axi_read(6'h0C, d, r);
        check("status_committed", d & 32'd1, 32'd0);

        // Duty boundaries and channel disable.
        axi_write(6'h14, 32'd0, 4'hF, 1'b1, r);
        axi_write(6'h18, 32'd20, 4'hF, 1'b1, r);
        axi_write(6'h04, 32'd9, 4'hF, 1'b1, r);
        axi_write(6'h00, 32'h80000006, 4'hF, 1'b1, r);
        capture_period();
        capture_period();
        check("ch0_off_h", 32'(h_pat[0]), 32'h000);
        check("ch0_off_l", 32'(l_pat[0]), 32'h000);
        check("ch1_duty0_h", 32'(h_pat[1]), 32'h000);
        check("ch1_duty0_l", 32'(l_pat[1]), 32'h3FF);
        check("ch2_dutybig_h", 32'(h_pat[2]), 32'h3FF);
        check("ch2_dutybig_l", 32'(l_pat[2]), 32'h000);
        check("ch3_off_hl", 32'({h_pat[3], l_pat[3]}), 32'h0);
        check("multi_overlap", 32'(win_overlap), 32'd0);

        // Byte strobes on a freshly reset PERIOD.
        aresetn = 1'b0;
        tick(); tick();
        aresetn = 1'b1;
        axi_read(6'h04, d, r);
        check("period_after_rst", d, 32'd0);
        axi_write(6'h04, 32'hFFFFFF05, 4'b0001, 1'b1, r);
        axi_read(6'h04, d, r);
        check("strb_byte0", d, 32'h0005);
        axi_write(6'h04, 32'h0000AB00, 4'b0010, 1'b1, r);
        axi_read(6'h04, d, r);
        check("strb_byte1", d, 32'hAB05);

        // Reset while a write response is pending.
        axi_write(6'h04, 32'd9, 4'hF, 1'b1, r);
        axi_write(6'h10, 32'd3, 4'hF, 1'b1, r);
        axi_write(6'h00, 32'h80000001, 4'hF, 1'b1, r);
        axi_write(6'h08, 32'd0, 4'hF, 1'b0, r);
        check("bvalid_pending", 32'(bvalid), 32'd1);
        check("drive_before_rst", 32'(|(pwm_h | pwm_l)), 32'd1);
        aresetn = 1'b0;
        tick();
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_pwm", 32'({pwm_h, pwm_l, period_irq}), 32'd0);
        aresetn = 1'b1;
        tick();
        axi_read(6'h00, d, r);
        check("ctrl_after_rst", d, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
